alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 118 +++++++++++
 tb/tb_alu_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Three-phase command sequencer (IDLE -> EXEC -> WB) driving an external
// registered ALU, with an NREGS x BITS register file and a debug read port.
package pck_control;
  typedef enum logic [3:0] {
    alu_cpa = 4'd0,
    alu_cpb = 4'd1,
    alu_add = 4'd2,
    alu_sub = 4'd3,
    alu_and = 4'd4,
    alu_or  = 4'd5,
    alu_xor = 4'd6,
    alu_inc = 4'd7
  } sel_alu_op_e;
endpackage

module alu_sequencer
  import pck_control::*;
#(
  parameter int BITS  = 8,
  parameter int NREGS = 8,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  sel_alu_op_e     i_cmd_op,
  input  logic [AW-1:0]   i_cmd_rd,
  input  logic [AW-1:0]   i_cmd_rs1,
  input  logic [AW-1:0]   i_cmd_rs2,
  input  logic            i_cmd_use_imm,
  input  logic [BITS-1:0] i_cmd_imm,
  output sel_alu_op_e     o_alu_sel_op,
  output logic [BITS-1:0] o_alu_op_a,
  output logic [BITS-1:0] o_alu_op_b,
  input  logic [BITS-1:0] i_alu_res,
  output logic            o_wb_valid,
  output logic [AW-1:0]   o_wb_addr,
  output logic [BITS-1:0] o_wb_data,
  input  logic [AW-1:0]   i_dbg_addr,
  output logic [BITS-1:0] o_dbg_data,
  output logic            o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_s;
  logic            accept_s;
  logic [AW-1:0]   rd_r;
  logic [BITS-1:0] rf_r [NREGS];

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and acceptance decode
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_cmd_valid) begin
          accept_s = 1'b1;
          state_s  = EXEC;
        end else begin
          state_s  = IDLE;
        end
      end
      EXEC:    state_s = WB;
      WB:      state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Operand launch: ALU inputs hold their value until the next accepted command
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_alu_sel_op <= alu_cpa;
      o_alu_op_a   <= {BITS{1'b0}};
      o_alu_op_b   <= {BITS{1'b0}};
      rd_r         <= {AW{1'b0}};
    end else if (accept_s) begin
      o_alu_sel_op <= i_cmd_op;
      o_alu_op_a   <= rf_r[i_cmd_rs1];
      o_alu_op_b   <= i_cmd_use_imm ? i_cmd_imm : rf_r[i_cmd_rs2];
      rd_r         <= i_cmd_rd;
    end
  end

  // Register file; entry 0 is never written so it stays at its reset value of zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_r[i] <= {BITS{1'b0}};
      end
    end else if ((state_r == WB) && (rd_r != {AW{1'b0}})) begin
      rf_r[rd_r] <= i_alu_res;
    end
  end

  assign o_cmd_ready = (state_r == IDLE);
  assign o_busy      = (state_r != IDLE);
  assign o_wb_valid  = (state_r == WB);
  assign o_wb_addr   = rd_r;
  assign o_wb_data   = i_alu_res;
  assign o_dbg_data  = (i_dbg_addr == {AW{1'b0}}) ? {BITS{1'b0}} : rf_r[i_dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with a behavioural ALU
// and an array-based register-file reference model.
module tb_alu_sequencer;
  import pck_control::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  sel_alu_op_e cmd_op;
  logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
  logic        cmd_use_imm;
  logic [7:0]  cmd_imm;
  sel_alu_op_e alu_sel_op;
  logic [7:0]  alu_op_a, alu_op_b, alu_res;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic [2:0]  dbg_addr;
  logic [7:0]  dbg_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] ref_rf [8];

  alu_sequencer #(.BITS(8), .NREGS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_rd(cmd_rd), .i_cmd_rs1(cmd_rs1), .i_cmd_rs2(cmd_rs2),
    .i_cmd_use_imm(cmd_use_imm), .i_cmd_imm(cmd_imm),
    .o_alu_sel_op(alu_sel_op), .o_alu_op_a(alu_op_a), .o_alu_op_b(alu_op_b),
    .i_alu_res(alu_res),
    .o_wb_valid(wb_valid), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
    .i_dbg_addr(dbg_addr), .o_dbg_data(dbg_data), .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour; unknown opcodes yield zero
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return a;
      4'd1:    return b;
      4'd2:    return a + b;
      4'd3:    return a - b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      4'd7:    return a + 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  // Registered ALU attached to the sequencer
  always_ff @(posedge clk) begin
    alu_res <= alu_f(alu_sel_op, alu_op_a, alu_op_b);
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check_eq(tag, {24'd0, dbg_data}, 32'd0);
    end
  endtask

  task automatic drive_junk();
    cmd_valid   = 1'($urandom);
    cmd_op      = sel_alu_op_e'(4'($urandom));
    cmd_rd      = 3'($urandom);
    cmd_rs1     = 3'($urandom);
    cmd_rs2     = 3'($urandom);
    cmd_use_imm = 1'($urandom);
    cmd_imm     = 8'($urandom);
  endtask

  // One full command: present in IDLE, check EXEC, WB and the following IDLE
  task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic use_imm, input logic [7:0] imm);
    logic [7:0] a, b, exp;
    int k;
    a   = ref_rf[rs1];
    b   = use_imm ? imm : ref_rf[rs2];
    exp = alu_f(op, a, b);
    @(negedge clk);
    k = 0;
    while (!cmd_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_eq("ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_op = sel_alu_op_e'(op); cmd_rd = rd; cmd_rs1 = rs1;
    cmd_rs2 = rs2; cmd_use_imm = use_imm; cmd_imm = imm;
    @(negedge clk);
    drive_junk();
    check_eq("exec_busy", {31'd0, busy}, 32'd1);
    check_eq("exec_ready", {31'd0, cmd_ready}, 32'd0);
    check_eq("exec_wbv", {31'd0, wb_valid}, 32'd0);
    check_eq("exec_op", {28'd0, 4'(alu_sel_op)}, {28'd0, op});
    check_eq("exec_a", {24'd0, alu_op_a}, {24'd0, a});
    check_eq("exec_b", {24'd0, alu_op_b}, {24'd0, b});
    dbg_addr = rd;
    @(negedge clk);
    check_eq("wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("wb_addr", {29'd0, wb_addr}, {29'd0, rd});
    check_eq("wb_data", {24'd0, wb_data}, {24'd0, exp});
    check_eq("wb_dbg_prewrite", {24'd0, dbg_data}, {24'd0, ref_rf[rd]});
    check_eq("wb_a_stable", {24'd0, alu_op_a}, {24'd0, a});
    cmd_valid = 1'b0;
    if (rd != 3'd0) ref_rf[rd] = exp;
    @(negedge clk);
    check_eq("post_wbv", {31'd0, wb_valid}, 32'd0);
    check_eq("post_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("post_dbg", {24'd0, dbg_data}, {24'd0, ref_rf[rd]});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = alu_cpa; cmd_rd = 3'd0; cmd_rs1 = 3'd0;
    cmd_rs2 = 3'd0; cmd_use_imm = 1'b0; cmd_imm = 8'h00; dbg_addr = 3'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check_eq("rst_op", {28'd0, 4'(alu_sel_op)}, 32'd0);
    check_all_zero("rst_dbg");

    issue(4'd1, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05);
    issue(4'd2, 3'd2, 3'd1, 3'd0, 1'b1, 8'hFC);
    issue(4'd1, 3'd0, 3'd0, 3'd0, 1'b1, 8'hAA);

    // Back-to-back dependent adds with valid held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = alu_add; cmd_rd = 3'd3; cmd_rs1 = 3'd2; cmd_rs2 = 3'd2;
    cmd_use_imm = 1'b0; dbg_addr = 3'd3;
    check_eq("b2b_ready0", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check_eq("b2b_ready1", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    check_eq("b2b_ready2", {31'd0, cmd_ready}, 32'd0);
    check_eq("b2b_res1", {24'd0, wb_data}, 32'h02);
    cmd_rs1 = 3'd3; cmd_rs2 = 3'd3;
    @(negedge clk);
    check_eq("b2b_ready3", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    check_eq("b2b_ready4", {31'd0, cmd_ready}, 32'd0);
    check_eq("b2b_a", {24'd0, alu_op_a}, 32'h02);
    @(negedge clk);
    check_eq("b2b_wbv", {31'd0, wb_valid}, 32'd1);
    check_eq("b2b_res2", {24'd0, wb_data}, 32'h04);
    cmd_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_dbg3", {24'd0, dbg_data}, 32'h04);
    ref_rf[3] = 8'h04;

    // Randomized commands, including opcodes outside the enum
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 8'($urandom));
    end

    // Reset during EXEC aborts the command
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = alu_cpb; cmd_rd = 3'd5; cmd_use_imm = 1'b1; cmd_imm = 8'h77;
    @(negedge clk);
    cmd_valid = 1'b0;
    check_eq("abort_in_exec", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    check_eq("abort_ready", {31'd0, cmd_ready}, 32'd1);
    for (int i = 0; i < 8; i++) ref_rf[i] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("abort_no_wb", {31'd0, wb_valid}, 32'd0);
      check_eq("abort_ready_after", {31'd0, cmd_ready}, 32'd1);
    end
    check_all_zero("abort_dbg");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
